zet_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one 16-bit Wishbone master port among four requesters (instruction fetch, data, DMA, debug).
- Holds a registered grant and a 2-bit select that steers the 4:1 address/data/control muxes onto the shared bus.
- Adds a bus watchdog so a dead slave cannot hang the CPU.
- Sits between the Zet core's bus masters and the system interconnect.

---
 rtl/zet_bus_arbiter.sv | 119 +++++++++++
 tb/tb_zet_bus_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zet_bus_arbiter.sv
// Round-robin arbiter sharing one 16-bit Wishbone master port among four requesters,
// with a registered grant, a locked-transfer hold and a stalled-slave watchdog.
module zet_bus_arbiter #(
  parameter int unsigned ADDR_W = 20,
  parameter logic [7:0]  TMO    = 8'd255  // must be at least 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            m_cyc_i,
  input  logic [3:0]            m_stb_i,
  input  logic [3:0]            m_we_i,
  input  logic [7:0]            m_sel_i,
  input  logic [4*ADDR_W-1:0]   m_adr_i,
  input  logic [63:0]           m_dat_i,
  output logic [15:0]           m_dat_o,
  output logic [3:0]            m_ack_o,
  output logic [3:0]            m_err_o,
  output logic                  s_cyc_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [1:0]            s_sel_o,
  output logic [ADDR_W-1:0]     s_adr_o,
  output logic [15:0]           s_dat_o,
  input  logic [15:0]           s_dat_i,
  input  logic                  s_ack_i,
  output logic [3:0]            gnt_o,
  output logic [1:0]            sel_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StRel} state_e;

  state_e      state_q;
  logic [3:0]  gnt_q;
  logic [1:0]  sel_q;
  logic [1:0]  ptr_q;
  logic [7:0]  cnt_q;
  logic [3:0]  err_q;
  logic [1:0]  pick;

  // Scan from the highest offset down so the requester nearest ptr_q wins.
  always_comb begin
    pick = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (m_cyc_i[ptr_q + 2'(i)]) begin
        pick = ptr_q + 2'(i);
      end
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (state_q == StBusy) begin
      s_cyc_o = m_cyc_i[sel_q];
      s_stb_o = m_stb_i[sel_q] & m_cyc_i[sel_q];
      s_we_o  = m_we_i[sel_q];
      s_sel_o = m_sel_i[2*int'(sel_q) +: 2];
      s_adr_o = m_adr_i[int'(sel_q)*ADDR_W +: ADDR_W];
      s_dat_o = m_dat_i[16*int'(sel_q) +: 16];
    end
    m_ack_o = {4{s_ack_i}} & gnt_q & m_stb_i;
  end

  assign m_dat_o = s_dat_i;
  assign m_err_o = err_q;
  assign gnt_o   = gnt_q;
  assign sel_o   = sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      err_q <= '0;
      case (state_q)
        StIdle: begin
          if (|m_cyc_i) begin
            gnt_q   <= 4'b0001 << pick;
            sel_q   <= pick;
            state_q <= StBusy;
          end
        end
        StBusy: begin
          if (!m_cyc_i[sel_q]) begin
            gnt_q   <= '0;
            ptr_q   <= sel_q + 2'd1;
            cnt_q   <= '0;
            state_q <= StRel;
          end else if (s_ack_i) begin
            // An ack in the would-be timeout cycle wins over the error.
            cnt_q <= '0;
          end else if (s_stb_o) begin
            if (cnt_q == TMO - 8'd1) begin
              cnt_q <= '0;
              err_q <= 4'b0001 << sel_q;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        StRel: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zet_bus_arbiter.sv
// Bench for zet_bus_arbiter: directed scenarios plus random traffic, all checked against
// an ownership-level reference model (owner, dead cycle, pointer, stall count).
module tb_zet_bus_arbiter;

  localparam int unsigned AW  = 20;
  localparam logic [7:0]  TMO = 8'd4;

  logic            clk;
  logic            rst;
  logic [3:0]      m_cyc_i;
  logic [3:0]      m_stb_i;
  logic [3:0]      m_we_i;
  logic [7:0]      m_sel_i;
  logic [4*AW-1:0] m_adr_i;
  logic [63:0]     m_dat_i;
  logic [15:0]     m_dat_o;
  logic [3:0]      m_ack_o;
  logic [3:0]      m_err_o;
  logic            s_cyc_o;
  logic            s_stb_o;
  logic            s_we_o;
  logic [1:0]      s_sel_o;
  logic [AW-1:0]   s_adr_o;
  logic [15:0]     s_dat_o;
  logic [15:0]     s_dat_i;
  logic            s_ack_i;
  logic [3:0]      gnt_o;
  logic [1:0]      sel_o;

  zet_bus_arbiter #(
    .ADDR_W (AW),
    .TMO    (TMO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_sel_i (m_sel_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_sel_o (s_sel_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .gnt_o   (gnt_o),
    .sel_o   (sel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus, whether a dead cycle is pending, etc.
  int         owner;
  int         rel_m;
  int         ptr_m;
  int         stall_m;
  int         last_sel;
  logic [3:0] err_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic model_reset();
    owner    = -1;
    rel_m    = 0;
    ptr_m    = 0;
    stall_m  = 0;
    last_sel = 0;
    err_m    = '0;
  endtask

  task automatic model_check();
    logic [3:0]    eg;
    logic [3:0]    ea;
    logic          ecyc;
    logic          estb;
    logic          ewe;
    logic [1:0]    esel;
    logic [AW-1:0] eadr;
    logic [15:0]   edat;
    eg = '0; ea = '0; ecyc = 1'b0; estb = 1'b0; ewe = 1'b0;
    esel = '0; eadr = '0; edat = '0;
    if (owner >= 0) begin
      eg   = 4'b0001 << owner;
      ecyc = m_cyc_i[owner];
      estb = ecyc & m_stb_i[owner];
      ewe  = m_we_i[owner];
      esel = m_sel_i[2*owner +: 2];
      eadr = m_adr_i[owner*AW +: AW];
      edat = m_dat_i[16*owner +: 16];
      ea[owner] = s_ack_i & m_stb_i[owner];
    end
    chk("gnt", 32'(gnt_o), 32'(eg));
    chk("sel", 32'(sel_o), 32'(last_sel));
    chk("s_cyc", 32'(s_cyc_o), 32'(ecyc));
    chk("s_stb", 32'(s_stb_o), 32'(estb));
    chk("s_we", 32'(s_we_o), 32'(ewe));
    chk("s_sel", 32'(s_sel_o), 32'(esel));
    chk("s_adr", 32'(s_adr_o), 32'(eadr));
    chk("s_dat", 32'(s_dat_o), 32'(edat));
    chk("m_ack", 32'(m_ack_o), 32'(ea));
    chk("m_err", 32'(m_err_o), 32'(err_m));
    chk("m_dat", 32'(m_dat_o), 32'(s_dat_i));
  endtask

  task automatic model_step();
    bit found;
    err_m = '0;
    if (owner >= 0) begin
      if (!m_cyc_i[owner]) begin
        ptr_m   = (owner + 1) % 4;
        owner   = -1;
        rel_m   = 1;
        stall_m = 0;
      end else if (s_ack_i) begin
        stall_m = 0;
      end else if (m_stb_i[owner]) begin
        stall_m++;
        if (stall_m == int'(TMO)) begin
          err_m   = 4'b0001 << owner;
          stall_m = 0;
        end
      end
    end else if (rel_m != 0) begin
      rel_m = 0;
    end else begin
      found = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (!found && m_cyc_i[(ptr_m + i) % 4]) begin
          found    = 1'b1;
          owner    = (ptr_m + i) % 4;
          last_sel = owner;
        end
      end
    end
  endtask

  // Called in the window just after a rising edge; returns just after the next one.
  task automatic tick();
    @(negedge clk);
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m_cyc_i = '0; m_stb_i = '0; m_we_i = '0; m_sel_i = '0;
    m_adr_i = '0; m_dat_i = '0; s_dat_i = '0; s_ack_i = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_data();
    logic [95:0] a;
    logic [63:0] d;
    a = {$urandom(), $urandom(), $urandom()};
    d = {$urandom(), $urandom()};
    m_adr_i = a[4*AW-1:0];
    m_dat_i = d;
    m_we_i  = 4'($urandom());
    m_sel_i = 8'($urandom());
    s_dat_i = 16'($urandom());
  endtask

  task automatic rand_inputs();
    for (int k = 0; k < 4; k++) begin
      if (m_cyc_i[k]) begin
        if ($urandom_range(0, 3) == 0) m_cyc_i[k] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        m_cyc_i[k] = 1'b1;
      end
    end
    m_stb_i = 4'($urandom());
    s_ack_i = ($urandom_range(0, 2) == 0);
    rand_data();
  endtask

  logic [3:0] rr_order [5];

  initial begin
    rr_order[0] = 4'b0001; rr_order[1] = 4'b0010; rr_order[2] = 4'b0100;
    rr_order[3] = 4'b1000; rr_order[4] = 4'b0001;
    clear_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_sel", 32'(sel_o), 32'h0);
    chk("rst_err", 32'(m_err_o), 32'h0);
    chk("rst_scyc", 32'(s_cyc_o), 32'h0);
    rst = 1'b0;

    // Single request from requester 2.
    rand_data();
    m_cyc_i = 4'b0100; m_stb_i = 4'b0100;
    tick();
    chk("single_gnt", 32'(gnt_o), 32'h4);
    chk("single_sel", 32'(sel_o), 32'h2);
    s_ack_i = 1'b1;
    #1;
    chk("single_ack", 32'(m_ack_o), 32'h4);
    chk("single_adr", 32'(s_adr_o), 32'(m_adr_i[2*AW +: AW]));
    tick();
    s_ack_i = 1'b0; m_cyc_i = '0; m_stb_i = '0;
    tick();
    tick();

    // Round robin with all four requesting, one beat each.
    do_reset();
    m_cyc_i = 4'b1111; m_stb_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_gnt", 32'(gnt_o), 32'(rr_order[i]));
      s_ack_i = 1'b1;
      tick();
      s_ack_i = 1'b0;
      m_cyc_i = m_cyc_i & ~rr_order[i];
      tick();
      chk("rr_rel", 32'(gnt_o), 32'h0);
      m_cyc_i = 4'b1111;
      tick();
    end
    m_cyc_i = '0;
    tick(); tick(); tick();

    // Locked three-beat transfer by requester 1 while requester 0 waits.
    do_reset();
    m_cyc_i = 4'b0010; m_stb_i = 4'b0011;
    tick();
    m_cyc_i = 4'b0011;
    for (int i = 0; i < 3; i++) begin
      s_ack_i = 1'b1;
      #1;
      chk("lock_ack", 32'(m_ack_o), 32'h2);
      tick();
      chk("lock_gnt", 32'(gnt_o), 32'h2);
    end
    s_ack_i = 1'b0; m_cyc_i = 4'b0001;
    tick();
    chk("lock_rel", 32'(gnt_o), 32'h0);
    tick();
    chk("lock_idle", 32'(gnt_o), 32'h0);
    tick();
    chk("lock_next", 32'(gnt_o), 32'h1);
    m_cyc_i = '0;
    tick(); tick(); tick();

    // Watchdog: four stalled strobes raise one error pulse.
    do_reset();
    m_cyc_i = 4'b1000; m_stb_i = 4'b1000;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wd_quiet", 32'(m_err_o), 32'h0);
    end
    tick();
    chk("wd_err", 32'(m_err_o), 32'h8);
    chk("wd_keep", 32'(gnt_o), 32'h8);
    tick();
    chk("wd_pulse", 32'(m_err_o), 32'h0);
    m_cyc_i = '0;
    tick(); tick();
    // Ack arrives in the fourth cycle: no error.
    m_cyc_i = 4'b1000;
    tick();
    tick(); tick(); tick();
    s_ack_i = 1'b1;
    tick();
    chk("wd_ackwin", 32'(m_err_o), 32'h0);
    s_ack_i = 1'b0;
    tick();
    chk("wd_after", 32'(m_err_o), 32'h0);
    m_cyc_i = '0;
    tick(); tick();

    // Asynchronous reset in the middle of a transfer.
    do_reset();
    m_cyc_i = 4'b0100; m_stb_i = 4'b0100;
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_gnt", 32'(gnt_o), 32'h0);
    chk("arst_cyc", 32'(s_cyc_o), 32'h0);
    chk("arst_stb", 32'(s_stb_o), 32'h0);
    model_reset();
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_cyc_i = 4'b0110;
    tick();
    chk("arst_regnt", 32'(gnt_o), 32'h2);
    chk("arst_sel", 32'(sel_o), 32'h1);

    // Pointer wrap: requester 3 releases, then 0 goes before 3.
    m_cyc_i = '0;
    tick(); tick(); tick();
    m_cyc_i = 4'b1000; m_stb_i = 4'b1000;
    tick();
    s_ack_i = 1'b1;
    tick();
    s_ack_i = 1'b0; m_cyc_i = '0;
    tick();
    m_cyc_i = 4'b1001; m_stb_i = 4'b1001;
    tick();
    tick();
    chk("wrap_first", 32'(gnt_o), 32'h1);
    m_cyc_i = 4'b1000;
    tick(); tick(); tick();
    chk("wrap_second", 32'(gnt_o), 32'h8);
    m_cyc_i = '0;
    tick(); tick(); tick();

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      rand_inputs();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
